// File: rtl/pm_pkg.sv
// Shared encodings for the power-domain sequencer and the power management logic.
package pm_pkg;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_SCAN     = 4'd1;
  localparam logic [3:0] ST_ISO_ON   = 4'd2;
  localparam logic [3:0] ST_CLK_OFF  = 4'd3;
  localparam logic [3:0] ST_WAIT_OFF = 4'd4;
  localparam logic [3:0] ST_CLK_ON   = 4'd5;
  localparam logic [3:0] ST_SETTLE   = 4'd6;
  localparam logic [3:0] ST_ISO_OFF  = 4'd7;
  localparam logic [3:0] ST_DONE     = 4'd8;

  localparam int DOMAIN_CORE  = 0;
  localparam int DOMAIN_CACHE = 1;
  localparam int DOMAIN_IO    = 2;
  localparam int DOMAIN_DEBUG = 3;

endpackage

// File: rtl/pm_domain_pick.sv
// Picks the next domain to sequence: highest domain to power down, else lowest to power up.
module pm_domain_pick
  import pm_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int IDX_W       = 2
) (
  input  logic [NUM_DOMAINS-1:0] current,
  input  logic [NUM_DOMAINS-1:0] tgt,
  output logic                   found_off,
  output logic [IDX_W-1:0]       off_idx,
  output logic                   found_on,
  output logic [IDX_W-1:0]       on_idx
);

  logic [NUM_DOMAINS-1:0] off_cand;
  logic [NUM_DOMAINS-1:0] on_cand;

  always_comb begin
    off_cand  = current & ~tgt;
    on_cand   = ~current & tgt;
    found_off = |off_cand;
    found_on  = |on_cand;
    off_idx   = '0;
    on_idx    = '0;
    // Ascending scan keeps the last hit (highest); descending keeps the lowest.
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (off_cand[i]) off_idx = IDX_W'(i);
    end
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      if (on_cand[i]) on_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/power_domain_sequencer.sv
// Walks power domains on/off one at a time with isolation-before-gating ordering
// and per-domain acknowledge handshakes with timeout.
module power_domain_sequencer
  import pm_pkg::*;
#(
  parameter  int NUM_DOMAINS   = 4,
  parameter  int SETTLE_CYCLES = 8,
  parameter  int ACK_TIMEOUT   = 64,
  localparam int IDX_W         = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [NUM_DOMAINS-1:0] target_mask,
  input  logic [NUM_DOMAINS-1:0] domain_ack,
  output logic [NUM_DOMAINS-1:0] domain_clk_enable,
  output logic [NUM_DOMAINS-1:0] domain_iso,
  output logic [NUM_DOMAINS-1:0] current_mask,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err,
  output logic [IDX_W-1:0]       err_domain
);

  localparam int              TW          = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0]   SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]   TO_LAST     = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0]   TIMER_MAX   = '1;

  logic [3:0]             state_q, state_d;
  logic [NUM_DOMAINS-1:0] tgt_q, tgt_d;
  logic [NUM_DOMAINS-1:0] cur_q, cur_d;
  logic [NUM_DOMAINS-1:0] clk_en_q, clk_en_d;
  logic [NUM_DOMAINS-1:0] iso_q, iso_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [IDX_W-1:0]       err_dom_q, err_dom_d;

  logic                   found_off, found_on;
  logic [IDX_W-1:0]       off_idx, on_idx;

  pm_domain_pick #(
    .NUM_DOMAINS (NUM_DOMAINS),
    .IDX_W       (IDX_W)
  ) u_pick (
    .current   (cur_q),
    .tgt       (tgt_q),
    .found_off (found_off),
    .off_idx   (off_idx),
    .found_on  (found_on),
    .on_idx    (on_idx)
  );

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    cur_d     = cur_q;
    clk_en_d  = clk_en_q;
    iso_d     = iso_q;
    idx_d     = idx_q;
    err_d     = err_q;
    err_dom_d = err_dom_q;
    timer_d   = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          tgt_d   = target_mask | NUM_DOMAINS'(1);
          err_d   = 1'b0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (found_off) begin
          idx_d   = off_idx;
          state_d = ST_ISO_ON;
        end else if (found_on) begin
          idx_d   = on_idx;
          state_d = ST_CLK_ON;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_ISO_ON: begin
        iso_d[idx_q] = 1'b1;
        state_d      = ST_CLK_OFF;
      end
      ST_CLK_OFF: begin
        clk_en_d[idx_q] = 1'b0;
        timer_d         = '0;
        state_d         = ST_WAIT_OFF;
      end
      ST_WAIT_OFF: begin
        if (!domain_ack[idx_q]) begin
          cur_d[idx_q] = 1'b0;
          state_d      = ST_SCAN;
        end else if (timer_q >= TO_LAST) begin
          err_d     = 1'b1;
          err_dom_d = idx_q;
          state_d   = ST_DONE;
        end
      end
      ST_CLK_ON: begin
        clk_en_d[idx_q] = 1'b1;
        timer_d         = '0;
        state_d         = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (timer_q >= SETTLE_LAST && domain_ack[idx_q]) begin
          state_d = ST_ISO_OFF;
        end else if (timer_q >= TO_LAST) begin
          err_d     = 1'b1;
          err_dom_d = idx_q;
          state_d   = ST_DONE;
        end
      end
      ST_ISO_OFF: begin
        iso_d[idx_q] = 1'b0;
        cur_d[idx_q] = 1'b1;
        state_d      = ST_SCAN;
      end
      default: state_d = ST_IDLE;
    endcase

    // done is registered so it is high exactly while the FSM sits in DONE.
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tgt_q     <= '1;
      cur_q     <= '1;
      clk_en_q  <= '1;
      iso_q     <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_dom_q <= '0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      cur_q     <= cur_d;
      clk_en_q  <= clk_en_d;
      iso_q     <= iso_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_dom_q <= err_dom_d;
    end
  end

  assign req_ready         = (state_q == ST_IDLE);
  assign busy              = (state_q != ST_IDLE);
  assign done              = done_q;
  assign domain_clk_enable = clk_en_q;
  assign domain_iso        = iso_q;
  assign current_mask      = cur_q;
  assign timeout_err       = err_q;
  assign err_domain        = err_dom_q;

endmodule

// File: tb/tb_power_domain_sequencer.sv
// Bench for power_domain_sequencer: table of requests with a behavioural ack model,
// expected results queued on accept and checked when done pulses.
module tb_power_domain_sequencer;

  localparam int S = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] target_mask = 4'b0000;
  logic [3:0] domain_ack = 4'b1111;
  logic [3:0] domain_clk_enable;
  logic [3:0] domain_iso;
  logic [3:0] current_mask;
  logic       busy;
  logic       done;
  logic       timeout_err;
  logic [1:0] err_domain;

  power_domain_sequencer #(
    .NUM_DOMAINS   (4),
    .SETTLE_CYCLES (S),
    .ACK_TIMEOUT   (64)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .target_mask       (target_mask),
    .domain_ack        (domain_ack),
    .domain_clk_enable (domain_clk_enable),
    .domain_iso        (domain_iso),
    .current_mask      (current_mask),
    .busy              (busy),
    .done              (done),
    .timeout_err       (timeout_err),
    .err_domain        (err_domain)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tm;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] cur;
    logic [3:0] clk;
    logic [3:0] iso;
    logic       err;
    logic [1:0] dom;
    int         lat;
    int         ord;
  } vec_t;

  vec_t vecs[11];
  vec_t sb[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int viol = 0;
  int ord = 0;
  int en_cyc[4] = '{-1000, -1000, -1000, -1000};
  int cnt[4] = '{2, 2, 2, 2};
  logic [3:0] stuck_lo = 4'b0000;
  logic [3:0] stuck_hi = 4'b0000;
  logic [3:0] p_clk = 4'b1111;
  logic [3:0] p_iso = 4'b0000;
  logic       rst_edge = 1'b1;

  always @(posedge clk) begin
    cyc++;
    rst_edge = rst;
  end

  // Domain model: ack rises two cycles after its clock enable, drops as soon as it is gated.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (domain_clk_enable[i]) cnt[i] = (cnt[i] >= 2) ? 2 : cnt[i] + 1;
      else cnt[i] = 0;
      if (stuck_hi[i]) domain_ack[i] = 1'b1;
      else if (stuck_lo[i]) domain_ack[i] = 1'b0;
      else domain_ack[i] = (cnt[i] >= 2);
    end
  end

  // Ordering/safety monitor on the gate-facing outputs.
  always @(negedge clk) begin
    if (!rst_edge) begin
      for (int i = 0; i < 4; i++) begin
        if (!domain_clk_enable[i] && !domain_iso[i]) viol++;
        if ((domain_clk_enable[i] !== p_clk[i]) && (domain_iso[i] !== p_iso[i])) viol++;
        if (domain_clk_enable[i] !== p_clk[i]) begin
          ord = ord * 10 + i;
          if (domain_clk_enable[i]) en_cyc[i] = cyc;
        end
        if (p_iso[i] && !domain_iso[i] && (cyc - en_cyc[i] < S)) viol++;
      end
      if (domain_clk_enable[0] !== 1'b1) viol++;
    end
    p_clk = domain_clk_enable;
    p_iso = domain_iso;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic issue(input vec_t v);
    @(negedge clk);
    target_mask = v.tm;
    stuck_lo    = v.lo;
    stuck_hi    = v.hi;
    ord         = 0;
    req_valid   = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    sb.push_back(v);
    chk("busy_after_accept", {busy, req_ready}, 2'b10);
  endtask

  task automatic wait_done();
    vec_t e;
    int   lat;
    logic got;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 300 && !got; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk("done_seen", got, 1'b1);
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      n_fail++;
      n_cmp++;
    end else begin
      e = sb.pop_front();
      chk("latency", lat, e.lat);
      chk("current_mask", current_mask, e.cur);
      chk("clk_enable", domain_clk_enable, e.clk);
      chk("iso", domain_iso, e.iso);
      chk("timeout_err", timeout_err, e.err);
      if (e.err) chk("err_domain", err_domain, e.dom);
      chk("clk_order", ord, e.ord);
      chk("safety_violations", viol, 0);
      @(posedge clk);
      #1;
      chk("done_one_cycle", {done, req_ready, busy}, 3'b010);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_clk_en"}, domain_clk_enable, 4'b1111);
    chk({tag, "_iso"}, domain_iso, 4'b0000);
    chk({tag, "_cur"}, current_mask, 4'b1111);
    chk({tag, "_ctl"}, {req_ready, busy, done, timeout_err}, 4'b1000);
    chk({tag, "_err_dom"}, err_domain, 2'd0);
  endtask

  initial begin
    //         tm       lo       hi       cur      clk      iso      err   dom  lat ord
    vecs[0]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b1110, 1'b0, 2'd0, 13, 321};
    vecs[1]  = '{4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 1'b0, 2'd0, 34, 123};
    vecs[2]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b1110, 1'b0, 2'd0, 13, 321};
    vecs[3]  = '{4'b0101, 4'b0000, 4'b0000, 4'b0101, 4'b0101, 4'b1010, 1'b0, 2'd0, 12, 2};
    vecs[4]  = '{4'b0101, 4'b0000, 4'b0000, 4'b0101, 4'b0101, 4'b1010, 1'b0, 2'd0, 1, 0};
    vecs[5]  = '{4'b1011, 4'b0000, 4'b0000, 4'b1011, 4'b1011, 4'b0100, 1'b0, 2'd0, 27, 213};
    vecs[6]  = '{4'b1111, 4'b0100, 4'b0000, 4'b1011, 4'b1111, 4'b0100, 1'b1, 2'd2, 66, 2};
    vecs[7]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0011, 4'b0111, 4'b1100, 1'b0, 2'd0, 5, 3};
    vecs[8]  = '{4'b0001, 4'b0000, 4'b0010, 4'b0011, 4'b0101, 4'b1110, 1'b1, 2'd1, 67, 1};
    vecs[9]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0011, 4'b0101, 4'b1110, 1'b0, 2'd0, 1, 0};
    vecs[10] = '{4'b0111, 4'b0000, 4'b0000, 4'b0111, 4'b0101, 4'b1010, 1'b0, 2'd0, 12, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals("reset");

    for (int v = 0; v < 11; v++) begin
      issue(vecs[v]);
      wait_done();
    end

    // Reset in the middle of a power-up settle window.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue(vecs[0]);
    wait_done();
    @(negedge clk);
    target_mask = 4'b0011;
    stuck_lo    = 4'b0000;
    stuck_hi    = 4'b0000;
    req_valid   = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("settle_mid_state", {busy, domain_clk_enable[1], domain_iso[1]}, 3'b111);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    issue(vecs[0]);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
